// File: rtl/isp_ccm_pkg.sv
// isp_ccm_pkg: default widths, unity coefficient, identity matrix and coefficient slot indices
package isp_ccm_pkg;
    localparam int CCM_BITS_DEF      = 8;
    localparam int CCM_COEF_BITS_DEF = 12;
    localparam int CCM_FRAC_DEF      = 8;
    localparam int CCM_ONE           = 1 << CCM_FRAC_DEF;
    localparam int CCM_RR = 0, CCM_RG = 1, CCM_RB = 2;
    localparam int CCM_GR = 3, CCM_GG = 4, CCM_GB = 5;
    localparam int CCM_BR = 6, CCM_BG = 7, CCM_BB = 8;
    localparam logic [9*CCM_COEF_BITS_DEF-1:0] CCM_IDENT = {
        CCM_COEF_BITS_DEF'(CCM_ONE), {3{CCM_COEF_BITS_DEF'(0)}},
        CCM_COEF_BITS_DEF'(CCM_ONE), {3{CCM_COEF_BITS_DEF'(0)}},
        CCM_COEF_BITS_DEF'(CCM_ONE)
    };
endpackage

// File: rtl/isp_ccm_if.sv
// isp_ccm_if: pixel stream bundle (href, vsync, r, g, b); master drives, slave receives
interface isp_ccm_if
    import isp_ccm_pkg::*;
#(
    parameter int BITS = CCM_BITS_DEF
);
    logic            href;
    logic            vsync;
    logic [BITS-1:0] r;
    logic [BITS-1:0] g;
    logic [BITS-1:0] b;
    modport master (output href, vsync, r, g, b);
    modport slave  (input  href, vsync, r, g, b);
endinterface

// File: rtl/isp_ccm_dot3.sv
// isp_ccm_dot3: one output channel of the matrix, 3-stage pipe (multiply, sum+round, shift/clamp/bypass)
//   pix  : {b, g, r} input pixel, r in the LSBs
//   coef : {m_x2, m_x1, m_x0} signed coefficients of this channel's row
//   en   : enable travelling with the pixel; 0 passes pix channel CH through unchanged
//   y    : corrected component, valid 3 pclk after pix
module isp_ccm_dot3
    import isp_ccm_pkg::*;
#(
    parameter int BITS      = CCM_BITS_DEF,
    parameter int COEF_BITS = CCM_COEF_BITS_DEF,
    parameter int CCM_FRAC  = CCM_FRAC_DEF,
    parameter int CH        = 0
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    input  logic [3*BITS-1:0]      pix,
    input  logic [3*COEF_BITS-1:0] coef,
    input  logic                   en,
    output logic [BITS-1:0]        y
);
    localparam int P = BITS + 1 + COEF_BITS;
    localparam int S = BITS + COEF_BITS + 3;
    localparam logic signed [S-1:0] RND  = S'(1 << (CCM_FRAC - 1));
    localparam logic signed [S-1:0] MAXV = S'((1 << BITS) - 1);
    logic signed [P-1:0] p [3];
    logic signed [S-1:0] sum;
    logic signed [S-1:0] sh;
    logic [BITS-1:0]     byp1, byp2;
    logic                en1, en2;
    always_comb sh = sum >>> CCM_FRAC;
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) p[k] <= '0;
            sum  <= '0;
            byp1 <= '0;
            byp2 <= '0;
            en1  <= 1'b0;
            en2  <= 1'b0;
            y    <= '0;
        end else begin
            for (int k = 0; k < 3; k++)
                p[k] <= P'($signed({1'b0, pix[k*BITS +: BITS]})) * P'($signed(coef[k*COEF_BITS +: COEF_BITS]));
            byp1 <= pix[CH*BITS +: BITS];
            en1  <= en;
            sum  <= S'(p[0]) + S'(p[1]) + S'(p[2]) + RND;
            byp2 <= byp1;
            en2  <= en1;
            y    <= !en2 ? byp2 : sh[S-1] ? '0 : (sh > MAXV) ? '1 : sh[BITS-1:0];
        end
    end
endmodule

// File: rtl/isp_ccm.sv
// isp_ccm: colour correction matrix with frame-synchronous double-buffered coefficients
//   pclk, rst_n : pixel clock, asynchronous active-low reset
//   in_if       : demosaic pixel stream (slave)
//   out_if      : corrected stream, href/vsync delayed 3 pclk, colours 0 while href low (master)
//   ccm_en      : live enable, sampled on the vsync rising edge
//   ccm_coef    : live 3x3 coefficients, index 0 (m_rr) in the LSBs, sampled on the vsync rising edge
module isp_ccm
    import isp_ccm_pkg::*;
#(
    parameter int BITS      = CCM_BITS_DEF,
    parameter int COEF_BITS = CCM_COEF_BITS_DEF,
    parameter int CCM_FRAC  = CCM_FRAC_DEF
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    isp_ccm_if.slave               in_if,
    isp_ccm_if.master              out_if,
    input  logic                   ccm_en,
    input  logic [9*COEF_BITS-1:0] ccm_coef
);
    function automatic logic [9*COEF_BITS-1:0] ident();
        logic [9*COEF_BITS-1:0] v = '0;
        v[CCM_RR*COEF_BITS +: COEF_BITS] = COEF_BITS'(1 << CCM_FRAC);
        v[CCM_GG*COEF_BITS +: COEF_BITS] = COEF_BITS'(1 << CCM_FRAC);
        v[CCM_BB*COEF_BITS +: COEF_BITS] = COEF_BITS'(1 << CCM_FRAC);
        return v;
    endfunction
    localparam logic [9*COEF_BITS-1:0] IDENT = ident();
    logic [9*COEF_BITS-1:0] sh_coef;
    logic                   sh_en;
    logic                   vs_q;
    logic [2:0]             href_d, vs_d;
    logic [3*BITS-1:0]      pix;
    logic [BITS-1:0]        y [3];
    assign pix = {in_if.b, in_if.g, in_if.r};
    // the shadow is read combinationally by stage 1, so a pixel in the load cycle still sees the old values
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sh_coef <= IDENT;
            sh_en   <= 1'b0;
            vs_q    <= 1'b0;
            href_d  <= '0;
            vs_d    <= '0;
        end else begin
            vs_q   <= in_if.vsync;
            href_d <= {href_d[1:0], in_if.href};
            vs_d   <= {vs_d[1:0], in_if.vsync};
            if (in_if.vsync && !vs_q) begin
                sh_coef <= ccm_coef;
                sh_en   <= ccm_en;
            end
        end
    end
    for (genvar c = 0; c < 3; c++) begin : g_ch
        isp_ccm_dot3 #(
            .BITS      (BITS),
            .COEF_BITS (COEF_BITS),
            .CCM_FRAC  (CCM_FRAC),
            .CH        (c)
        ) u_dot3 (
            .pclk  (pclk),
            .rst_n (rst_n),
            .pix   (pix),
            .coef  (sh_coef[3*c*COEF_BITS +: 3*COEF_BITS]),
            .en    (sh_en),
            .y     (y[c])
        );
    end
    assign out_if.href  = href_d[2];
    assign out_if.vsync = vs_d[2];
    assign out_if.r     = href_d[2] ? y[0] : '0;
    assign out_if.g     = href_d[2] ? y[1] : '0;
    assign out_if.b     = href_d[2] ? y[2] : '0;
endmodule

// File: tb/tb_isp_ccm.sv
// tb_isp_ccm: table-driven and sequence checks of isp_ccm through an expected-output queue
module tb_isp_ccm;
    import isp_ccm_pkg::*;
    localparam int CB = CCM_COEF_BITS_DEF;

    typedef struct packed {
        logic       href;
        logic       vsync;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    typedef struct {
        int cs;
        int r, g, b;
        int er, eg, eb;
    } vec_t;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ccm_en = 1'b0;
    logic [9*CB-1:0] ccm_coef = '0;
    pix_t          exp_q[$];
    vec_t          tbl[10];
    int            n_vec = 0;
    int            n_err = 0;
    int            cur;

    isp_ccm_if in_if ();
    isp_ccm_if out_if ();

    isp_ccm dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .in_if    (in_if),
        .out_if   (out_if),
        .ccm_en   (ccm_en),
        .ccm_coef (ccm_coef)
    );

    always #5 pclk = ~pclk;

    task automatic put(input int idx, input int v);
        ccm_coef[idx*CB +: CB] = CB'(v);
    endtask

    // 0 identity, 1 R/B swap, 2 clamp (m_rr=2.0, m_rg=-1.0), 3 rounding (m_rr=0.5)
    task automatic set_live(input int cs, input bit en);
        ccm_en = en;
        ccm_coef = (cs == 1) ? '0 : CCM_IDENT;
        if (cs == 1) begin
            put(CCM_RB, 256);
            put(CCM_GG, 256);
            put(CCM_BR, 256);
        end
        if (cs == 2) begin
            put(CCM_RR, 512);
            put(CCM_RG, -256);
        end
        if (cs == 3) put(CCM_RR, 128);
    endtask

    task automatic prefill();
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
    endtask

    // called at a negedge: check the output due now, drive the next input, queue its expectation
    task automatic step(input bit h, input bit v, input int r, input int g, input int b,
                        input int er, input int eg, input int eb);
        pix_t a, e;
        a = '{out_if.href, out_if.vsync, out_if.r, out_if.g, out_if.b};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard empty at vector %0d", n_vec);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL pix%0d got href=%0b vs=%0b rgb=(%0d,%0d,%0d) want href=%0b vs=%0b rgb=(%0d,%0d,%0d)",
                         n_vec, a.href, a.vsync, a.r, a.g, a.b, e.href, e.vsync, e.r, e.g, e.b);
            end
        end
        in_if.href  = h;
        in_if.vsync = v;
        in_if.r     = 8'(r);
        in_if.g     = 8'(g);
        in_if.b     = 8'(b);
        exp_q.push_back('{h, v, h ? 8'(er) : 8'd0, h ? 8'(eg) : 8'd0, h ? 8'(eb) : 8'd0});
        @(negedge pclk);
    endtask

    task automatic frame(input int cs, input bit en);
        set_live(cs, en);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tbl[0] = '{1, 200, 100,  50,  50, 100, 200};
        tbl[1] = '{1,   1,   2,   3,   3,   2,   1};
        tbl[2] = '{1,   0, 255,  17,  17, 255,   0};
        tbl[3] = '{2, 200,   0,   0, 255,   0,   0};
        tbl[4] = '{2,   0, 100,   0,   0, 100,   0};
        tbl[5] = '{2, 100,  50,   7, 150,  50,   7};
        tbl[6] = '{3,   3,   7,   9,   2,   7,   9};
        tbl[7] = '{3,   1,   0,   0,   1,   0,   0};
        tbl[8] = '{3, 255, 255, 255, 128, 255, 255};
        tbl[9] = '{3,   2,   0,   0,   1,   0,   0};
        in_if.href = 1'b0;
        in_if.vsync = 1'b0;
        in_if.r = '0;
        in_if.g = '0;
        in_if.b = '0;
        set_live(1, 1);
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        prefill();
        // live swap/enable must be ignored before the first vsync edge
        step(1, 0, 10, 20, 30, 10, 20, 30);
        step(0, 0, 10, 20, 30,  0,  0,  0);
        step(1, 0, 10, 20, 30, 10, 20, 30);
        frame(0, 1);
        for (int i = 0; i < 256; i++) step(1, 0, i, i, i, i, i, i);
        cur = -1;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].cs != cur) begin
                cur = tbl[i].cs;
                frame(cur, 1);
            end
            step(1, 0, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].er, tbl[i].eg, tbl[i].eb);
        end
        // pixel in the vsync rising-edge cycle still uses the rounding matrix
        set_live(1, 1);
        step(1, 1, 7, 8, 9, 4, 8, 9);
        step(1, 0, 200, 100, 50, 50, 100, 200);
        set_live(2, 1);
        step(1, 0, 200, 100, 50, 50, 100, 200);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 200, 0, 0, 255, 0, 0);
        frame(2, 0);
        step(1, 0, 200, 0, 0, 200, 0, 0);
        step(1, 0, 0, 100, 0, 0, 100, 0);
        frame(1, 1);
        step(1, 0, 1, 2, 3, 3, 2, 1);
        step(1, 0, 4, 5, 6, 6, 5, 4);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_if.href, out_if.vsync, out_if.r, out_if.g, out_if.b} !== '0) begin
            n_err++;
            $display("FAIL reset_clear got href=%0b vs=%0b rgb=(%0d,%0d,%0d) want all 0",
                     out_if.href, out_if.vsync, out_if.r, out_if.g, out_if.b);
        end
        @(negedge pclk);
        rst_n = 1'b1;
        prefill();
        // shadow back to bypass although live still holds swap with enable
        step(1, 0, 1, 2, 3, 1, 2, 3);
        step(1, 0, 9, 0, 250, 9, 0, 250);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
